// File: rtl/writeback_unit_pkg.sv
// Shared CPU definitions used by the register file, the execute stage and
// the writeback unit.
//   REG_IDX_W / NUM_REGS : register index width and register count
//   DATA_W               : default result / register data width
//   wb_beat_t            : one writeback beat (destination index + data)
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_beat_t;

endpackage : cpu_pkg

// File: rtl/writeback_unit_if.sv
// Bundle of every non-clock signal of the writeback unit.
//   master : producers / decode side (drives valids, indices, data, claims)
//   slave  : the writeback unit (drives readies, register file port,
//            busy mask and the r0 drop pulse)
interface writeback_unit_if #(
    parameter int DATA_W = cpu_pkg::DATA_W
);
    import cpu_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [DATA_W-1:0]    alu_data;

    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_rd;
    logic [DATA_W-1:0]    mem_data;

    logic                 claim_valid;
    logic [REG_IDX_W-1:0] claim_rd;

    logic                 rf_write_enable;
    logic [REG_IDX_W-1:0] rf_rd_index;
    logic [DATA_W-1:0]    rf_rd_data;

    logic [NUM_REGS-1:0]  busy_mask;
    logic                 dropped_r0;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output claim_valid, claim_rd,
        input  alu_ready, mem_ready,
        input  rf_write_enable, rf_rd_index, rf_rd_data,
        input  busy_mask, dropped_r0
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  claim_valid, claim_rd,
        output alu_ready, mem_ready,
        output rf_write_enable, rf_rd_index, rf_rd_data,
        output busy_mask, dropped_r0
    );

endinterface : writeback_unit_if

// File: rtl/writeback_unit_hold_slot.sv
// wb_hold_slot: one-entry holding register for a single result producer.
//   clk, reset     : clock, asynchronous active-low reset
//   in_valid/ready : producer handshake; ready depends on state and take only
//   in_rd, in_data : offered beat
//   take           : this slot wins arbitration this cycle
//   hold_valid/rd/data : buffered beat
//   drop_r0        : an accepted beat targeted r0 and was discarded
module wb_hold_slot
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 take,
    output logic                 hold_valid,
    output logic [REG_IDX_W-1:0] hold_rd,
    output logic [DATA_W-1:0]    hold_data,
    output logic                 drop_r0
);

    logic                 valid_q, valid_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 accept;

    always_comb begin
        in_ready = !valid_q || take;
        accept   = in_valid && in_ready;
        drop_r0  = accept && (in_rd == '0);
        valid_d  = valid_q;
        rd_d     = rd_q;
        data_d   = data_q;
        // An accept only happens when the slot is empty or being drained,
        // so an r0 beat always leaves the slot empty.
        if (accept) begin
            valid_d = (in_rd != '0);
            rd_d    = in_rd;
            data_d  = in_data;
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_rd    = rd_q;
    assign hold_data  = data_q;

endmodule : wb_hold_slot

// File: rtl/writeback_unit.sv
// writeback_unit: register file write-side front end.
// Buffers the ALU and load/mult-div producers in one-entry slots, picks one
// write per cycle, registers the register file write port and tracks the
// pending-destination scoreboard used for decode hazard stalls.
//   clk, reset : clock, asynchronous active-low reset
//   wb         : slave side of writeback_unit_if (producers, claims,
//                register file port, busy_mask, dropped_r0)
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = cpu_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    writeback_unit_if.slave wb
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                 alu_hv, mem_hv;
    logic [REG_IDX_W-1:0] alu_hrd, mem_hrd;
    logic [DATA_W-1:0]    alu_hdata, mem_hdata;
    logic                 alu_drop, mem_drop;
    logic                 sel_alu, sel_mem;

    logic [CNT_W-1:0]     starve_q, starve_d;
    logic                 we_q, we_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 dropped_q, dropped_d;

    wb_hold_slot #(.DATA_W(DATA_W)) u_alu_slot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wb.alu_valid),
        .in_ready  (wb.alu_ready),
        .in_rd     (wb.alu_rd),
        .in_data   (wb.alu_data),
        .take      (sel_alu),
        .hold_valid(alu_hv),
        .hold_rd   (alu_hrd),
        .hold_data (alu_hdata),
        .drop_r0   (alu_drop)
    );

    wb_hold_slot #(.DATA_W(DATA_W)) u_mem_slot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wb.mem_valid),
        .in_ready  (wb.mem_ready),
        .in_rd     (wb.mem_rd),
        .in_data   (wb.mem_data),
        .take      (sel_mem),
        .hold_valid(mem_hv),
        .hold_rd   (mem_hrd),
        .hold_data (mem_hdata),
        .drop_r0   (mem_drop)
    );

    always_comb begin
        // The multi-cycle path is preferred; the counter guarantees the ALU
        // a slot after STARVE_LIMIT consecutive losses.
        sel_alu = alu_hv && (!mem_hv || (starve_q == LIMIT));
        sel_mem = mem_hv && !sel_alu;

        starve_d = starve_q;
        if (!alu_hv || sel_alu) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end

        we_d   = sel_alu || sel_mem;
        idx_d  = idx_q;
        data_d = data_q;
        if (sel_alu) begin
            idx_d  = alu_hrd;
            data_d = alu_hdata;
        end else if (sel_mem) begin
            idx_d  = mem_hrd;
            data_d = mem_hdata;
        end

        // Claim is applied after the clear so a same-index claim wins.
        busy_d = busy_q;
        if (we_d) begin
            busy_d[idx_d] = 1'b0;
        end
        if (wb.claim_valid && (wb.claim_rd != '0)) begin
            busy_d[wb.claim_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        dropped_d = alu_drop || mem_drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q  <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            busy_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign wb.rf_write_enable = we_q;
    assign wb.rf_rd_index     = idx_q;
    assign wb.rf_rd_data      = data_q;
    assign wb.busy_mask       = busy_q;
    assign wb.dropped_r0      = dropped_q;

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit: drives the producer and claim
// inputs through the interface and checks the register file port, the
// readies, the busy mask and the r0 drop pulse against hand-computed values.
module tb_writeback_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    writeback_unit_if #(.DATA_W(32)) wb_if ();

    writeback_unit #(.STARVE_LIMIT(4), .DATA_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                 input logic cv, input logic [4:0] crd);
        wb_if.alu_valid   = av;
        wb_if.alu_rd      = ard;
        wb_if.alu_data    = adata;
        wb_if.mem_valid   = mv;
        wb_if.mem_rd      = mrd;
        wb_if.mem_data    = mdata;
        wb_if.claim_valid = cv;
        wb_if.claim_rd    = crd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int exp_idx [10];
        errors = 0;
        checks = 0;
        exp_idx = '{3, 3, 3, 3, 4, 3, 3, 3, 3, 4};

        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("reset_we",      32'(wb_if.rf_write_enable), 32'd0);
        checkOutput("reset_idx",     32'(wb_if.rf_rd_index),     32'd0);
        checkOutput("reset_data",    wb_if.rf_rd_data,           32'd0);
        checkOutput("reset_busy",    wb_if.busy_mask,            32'd0);
        checkOutput("reset_dropped", 32'(wb_if.dropped_r0),      32'd0);
        tick();
        tick();
        reset = 1'b1;

        $display("[TB] single ALU beat");
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu_ready_held", 32'(wb_if.alu_ready),       32'd1);
        checkOutput("alu_we_early",   32'(wb_if.rf_write_enable), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu_we",    32'(wb_if.rf_write_enable), 32'd1);
        checkOutput("alu_idx",   32'(wb_if.rf_rd_index),     32'd5);
        checkOutput("alu_data",  wb_if.rf_rd_data,           32'hDEADBEEF);
        checkOutput("alu_ready", 32'(wb_if.alu_ready),       32'd1);
        tick();
        checkOutput("alu_we_off",   32'(wb_if.rf_write_enable), 32'd0);
        checkOutput("alu_idx_hold", 32'(wb_if.rf_rd_index),     32'd5);

        $display("[TB] starvation arbitration");
        applyStimulus(1, 5'd4, 32'h0000_00AA, 1, 5'd3, 32'h0000_00BB, 0, 0);
        tick();
        checkOutput("starve_alu_ready", 32'(wb_if.alu_ready), 32'd0);
        checkOutput("starve_mem_ready", 32'(wb_if.mem_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("starve_we_%0d", i),  32'(wb_if.rf_write_enable), 32'd1);
            checkOutput($sformatf("starve_idx_%0d", i), 32'(wb_if.rf_rd_index),     32'(exp_idx[i]));
            checkOutput($sformatf("starve_dat_%0d", i), wb_if.rf_rd_data,
                        (exp_idx[i] == 4) ? 32'h0000_00AA : 32'h0000_00BB);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("drain_idx0", 32'(wb_if.rf_rd_index), 32'd3);
        tick();
        checkOutput("drain_idx1", 32'(wb_if.rf_rd_index), 32'd4);
        tick();
        checkOutput("drain_we", 32'(wb_if.rf_write_enable), 32'd0);

        $display("[TB] r0 filter");
        applyStimulus(1, 5'd0, 32'h0000_1234, 0, 0, 0, 0, 0);
        tick();
        checkOutput("r0_dropped", 32'(wb_if.dropped_r0), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("r0_dropped_off", 32'(wb_if.dropped_r0),      32'd0);
        checkOutput("r0_no_write",    32'(wb_if.rf_write_enable), 32'd0);
        applyStimulus(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 0, 0);
        tick();
        checkOutput("r0_both_dropped", 32'(wb_if.dropped_r0), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("r0_both_off",  32'(wb_if.dropped_r0),      32'd0);
        checkOutput("r0_both_nowr", 32'(wb_if.rf_write_enable), 32'd0);

        $display("[TB] scoreboard");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        tick();
        checkOutput("claim7_set", wb_if.busy_mask, 32'h0000_0080);
        applyStimulus(1, 5'd7, 32'h0000_0077, 0, 0, 0, 0, 0);
        tick();
        checkOutput("claim7_held", wb_if.busy_mask, 32'h0000_0080);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("claim7_idx",   32'(wb_if.rf_rd_index), 32'd7);
        checkOutput("claim7_clear", wb_if.busy_mask,        32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0);
        tick();
        checkOutput("claim0_ignored", wb_if.busy_mask, 32'd0);
        applyStimulus(1, 5'd9, 32'h0000_0099, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        tick();
        checkOutput("claim9_idx",  32'(wb_if.rf_rd_index), 32'd9);
        checkOutput("claim9_kept", wb_if.busy_mask,        32'h0000_0200);
        applyStimulus(1, 5'd9, 32'h0000_0999, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("claim9_data",  wb_if.rf_rd_data, 32'h0000_0999);
        checkOutput("claim9_clear", wb_if.busy_mask,  32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 5'd10, 32'h0000_0A0A, 1, 5'd11, 32'h0000_0B0B, 1, 5'd12);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pre_rst_idx",  32'(wb_if.rf_rd_index), 32'd11);
        checkOutput("pre_rst_busy", wb_if.busy_mask,        32'h0000_1000);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_we",        32'(wb_if.rf_write_enable), 32'd0);
        checkOutput("rst_idx",       32'(wb_if.rf_rd_index),     32'd0);
        checkOutput("rst_data",      wb_if.rf_rd_data,           32'd0);
        checkOutput("rst_busy",      wb_if.busy_mask,            32'd0);
        checkOutput("rst_alu_ready", 32'(wb_if.alu_ready),       32'd1);
        checkOutput("rst_mem_ready", 32'(wb_if.mem_ready),       32'd1);
        #2;
        reset = 1'b1;
        tick();
        checkOutput("post_rst_we0",  32'(wb_if.rf_write_enable), 32'd0);
        tick();
        checkOutput("post_rst_we1",  32'(wb_if.rf_write_enable), 32'd0);
        checkOutput("post_rst_rdy",  32'({wb_if.alu_ready, wb_if.mem_ready}), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_unit
